issue_queue_mult: RTL and testbench

- Reservation-station style issue queue directly upstream of the multiplier wrapper.
- Holds dispatched multiply instructions and captures missing source operands from CDB broadcasts.
- Issues the oldest ready entry per cycle onto the multiplier's rsdata/rtdata/rdtag inputs.
- The multiplier has no enable or stall, so the queue also tracks the fixed pipeline latency and flags when each product and tag are valid at the multiplier output.

---
 rtl/issue_queue_mult.sv | 167 ++++++++++++++++
 tb/tb_issue_queue_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_mult.sv
// Reservation-station issue queue feeding a fixed-latency multiplier.
// Captures operands from the CDB, issues the oldest ready entry, and tracks product completion.
module issue_queue_mult #(
  parameter int DEPTH        = 4,
  parameter int TAG_W        = 6,
  parameter int MULT_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_en,
  input  logic [31:0]      dispatch_rsdata,
  input  logic [TAG_W-1:0] dispatch_rstag,
  input  logic             dispatch_rsvalid,
  input  logic [31:0]      dispatch_rtdata,
  input  logic [TAG_W-1:0] dispatch_rttag,
  input  logic             dispatch_rtvalid,
  input  logic [TAG_W-1:0] dispatch_rdtag,
  output logic             issueque_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      issuemult_rsdata,
  output logic [31:0]      issuemult_rtdata,
  output logic [TAG_W-1:0] issuemult_rdtag,
  output logic             issuemult_enable,
  output logic             issuemult_done,
  output logic [TAG_W-1:0] issuemult_done_rdtag
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [31:0]      rs_data;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_rdy;
    logic [31:0]      rt_data;
    logic [TAG_W-1:0] rt_tag;
    logic             rt_rdy;
    logic [TAG_W-1:0] rdtag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH+1];
  entry_t           sel_ent;
  entry_t           new_ent;
  logic [DEPTH-1:0] sel_oh;
  logic             sel_hit;
  logic             do_disp;
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic             full_q, full_d;

  logic [31:0]      iss_rs_q, iss_rs_d, iss_rt_q, iss_rt_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic             iss_en_q, iss_en_d;

  logic [MULT_LATENCY-1:0] done_vld_q, done_vld_d;
  logic [TAG_W-1:0]        done_tag_q [MULT_LATENCY];
  logic [TAG_W-1:0]        done_tag_d [MULT_LATENCY];

  // Oldest-first select looks only at registered state, so a same-cycle wakeup cannot issue.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    sel_hit = 1'b0;
    sel_ent = '0;
    sel_oh  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_hit && ent_q[i].valid && ent_q[i].rs_rdy && ent_q[i].rt_rdy) begin
        sel_hit   = 1'b1;
        sel_ent   = ent_q[i];
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].rs_rdy && ent_q[i].rs_tag == cdb_tag) begin
          woke[i].rs_data = cdb_data;
          woke[i].rs_rdy  = 1'b1;
        end
        if (!ent_q[i].rt_rdy && ent_q[i].rt_tag == cdb_tag) begin
          woke[i].rt_data = cdb_data;
          woke[i].rt_rdy  = 1'b1;
        end
      end
    end
    woke[DEPTH] = '0;
  end

  always_comb begin
    do_disp         = dispatch_en && !full_q;
    new_ent.valid   = 1'b1;
    new_ent.rs_tag  = dispatch_rstag;
    new_ent.rt_tag  = dispatch_rttag;
    new_ent.rdtag   = dispatch_rdtag;
    new_ent.rs_rdy  = dispatch_rsvalid || (cdb_valid && cdb_tag == dispatch_rstag);
    new_ent.rs_data = dispatch_rsvalid ? dispatch_rsdata : cdb_data;
    new_ent.rt_rdy  = dispatch_rtvalid || (cdb_valid && cdb_tag == dispatch_rttag);
    new_ent.rt_data = dispatch_rtvalid ? dispatch_rtdata : cdb_data;
  end

  // Compaction: slots at or above the issued entry take their younger neighbour.
  always_comb begin
    logic shift;
    shift   = 1'b0;
    wr_idx  = count_q - CNT_W'(sel_hit);
    for (int i = 0; i < DEPTH; i++) begin
      shift    = shift | sel_oh[i];
      ent_d[i] = shift ? woke[i+1] : woke[i];
      if (do_disp && CNT_W'(i) == wr_idx) ent_d[i] = new_ent;
    end
    count_d = count_q + CNT_W'(do_disp) - CNT_W'(sel_hit);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_comb begin
    iss_en_d  = sel_hit;
    iss_rs_d  = sel_hit ? sel_ent.rs_data : iss_rs_q;
    iss_rt_d  = sel_hit ? sel_ent.rt_data : iss_rt_q;
    iss_tag_d = sel_hit ? sel_ent.rdtag   : iss_tag_q;
    done_vld_d[0] = iss_en_q;
    done_tag_d[0] = iss_tag_q;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      done_vld_d[i] = done_vld_q[i-1];
      done_tag_d[i] = done_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: entry storage is reset too, so a reset mid-operation leaves no stale ready entries.
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) done_tag_q[i] <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      iss_rs_q   <= '0;
      iss_rt_q   <= '0;
      iss_tag_q  <= '0;
      iss_en_q   <= 1'b0;
      done_vld_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      for (int i = 0; i < MULT_LATENCY; i++) done_tag_q[i] <= done_tag_d[i];
      count_q    <= count_d;
      full_q     <= full_d;
      iss_rs_q   <= iss_rs_d;
      iss_rt_q   <= iss_rt_d;
      iss_tag_q  <= iss_tag_d;
      iss_en_q   <= iss_en_d;
      done_vld_q <= done_vld_d;
    end
  end

  assign issueque_full        = full_q;
  assign issuemult_rsdata     = iss_rs_q;
  assign issuemult_rtdata     = iss_rt_q;
  assign issuemult_rdtag      = iss_tag_q;
  assign issuemult_enable     = iss_en_q;
  assign issuemult_done       = done_vld_q[MULT_LATENCY-1];
  assign issuemult_done_rdtag = done_tag_q[MULT_LATENCY-1];

endmodule

// File: tb/tb_issue_queue_mult.sv
// Directed bench for issue_queue_mult: wakeup, bypass, full, ordering, latency and reset.
module tb_issue_queue_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_en;
  logic [31:0] dispatch_rsdata, dispatch_rtdata;
  logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
  logic        dispatch_rsvalid, dispatch_rtvalid;
  logic        issueque_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [31:0] issuemult_rsdata, issuemult_rtdata;
  logic [5:0]  issuemult_rdtag, issuemult_done_rdtag;
  logic        issuemult_enable, issuemult_done;

  int n_cmp = 0;
  int n_err = 0;

  issue_queue_mult #(.DEPTH(4), .TAG_W(6), .MULT_LATENCY(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .dispatch_en          (dispatch_en),
    .dispatch_rsdata      (dispatch_rsdata),
    .dispatch_rstag       (dispatch_rstag),
    .dispatch_rsvalid     (dispatch_rsvalid),
    .dispatch_rtdata      (dispatch_rtdata),
    .dispatch_rttag       (dispatch_rttag),
    .dispatch_rtvalid     (dispatch_rtvalid),
    .dispatch_rdtag       (dispatch_rdtag),
    .issueque_full        (issueque_full),
    .cdb_valid            (cdb_valid),
    .cdb_tag              (cdb_tag),
    .cdb_data             (cdb_data),
    .issuemult_rsdata     (issuemult_rsdata),
    .issuemult_rtdata     (issuemult_rtdata),
    .issuemult_rdtag      (issuemult_rdtag),
    .issuemult_enable     (issuemult_enable),
    .issuemult_done       (issuemult_done),
    .issuemult_done_rdtag (issuemult_done_rdtag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] rsd, input logic [5:0] rst, input logic rsv,
                      input logic [31:0] rtd, input logic [5:0] rtt, input logic rtv,
                      input logic [5:0] rdt);
    dispatch_en      = 1'b1;
    dispatch_rsdata  = rsd;
    dispatch_rstag   = rst;
    dispatch_rsvalid = rsv;
    dispatch_rtdata  = rtd;
    dispatch_rttag   = rtt;
    dispatch_rtvalid = rtv;
    dispatch_rdtag   = rdt;
  endtask

  task automatic no_disp();
    dispatch_en = 1'b0; dispatch_rsvalid = 1'b0; dispatch_rtvalid = 1'b0;
    dispatch_rsdata = '0; dispatch_rtdata = '0;
    dispatch_rstag = '0; dispatch_rttag = '0; dispatch_rdtag = '0;
  endtask

  task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  task automatic check_issue(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [5:0] rd);
    check({tag, "_en"}, {31'd0, issuemult_enable}, 32'd1);
    check({tag, "_rs"}, issuemult_rsdata, rs);
    check({tag, "_rt"}, issuemult_rtdata, rt);
    check({tag, "_rd"}, {26'd0, issuemult_rdtag}, {26'd0, rd});
  endtask

  task automatic check_done(input string tag, input logic [5:0] rd);
    check({tag, "_done"}, {31'd0, issuemult_done}, 32'd1);
    check({tag, "_dtag"}, {26'd0, issuemult_done_rdtag}, {26'd0, rd});
  endtask

  initial begin
    reset = 1'b1;
    no_disp();
    cdb(1'b0, '0, '0);
    tick(2);
    check("rst_en",   {31'd0, issuemult_enable}, 32'd0);
    check("rst_done", {31'd0, issuemult_done}, 32'd0);
    check("rst_full", {31'd0, issueque_full}, 32'd0);
    check("rst_rs",   issuemult_rsdata, 32'd0);
    check("rst_dtag", {26'd0, issuemult_done_rdtag}, 32'd0);
    reset = 1'b0;

    // Both operands ready at dispatch: issue two cycles later, done four after that.
    disp(32'd3, 6'h00, 1'b1, 32'd5, 6'h00, 1'b1, 6'h12);
    tick(1); no_disp();
    check("t1_en_early", {31'd0, issuemult_enable}, 32'd0);
    tick(1); check_issue("t1", 32'd3, 32'd5, 6'h12);
    tick(1); check("t1_en_pulse", {31'd0, issuemult_enable}, 32'd0);
    tick(2); check("t1_done_early", {31'd0, issuemult_done}, 32'd0);
    tick(1); check_done("t1", 6'h12);
    tick(1); check("t1_done_pulse", {31'd0, issuemult_done}, 32'd0);

    // rs waits on tag 0x07; broadcast three cycles after dispatch.
    disp(32'hDEAD, 6'h07, 1'b0, 32'd2, 6'h00, 1'b1, 6'h20);
    tick(1); no_disp();
    check("t2_wait1", {31'd0, issuemult_enable}, 32'd0);
    tick(1); check("t2_wait2", {31'd0, issuemult_enable}, 32'd0);
    tick(1); cdb(1'b1, 6'h07, 32'h1234);
    check("t2_wait3", {31'd0, issuemult_enable}, 32'd0);
    tick(1); cdb(1'b0, '0, '0);
    check("t2_wake_cycle", {31'd0, issuemult_enable}, 32'd0);
    tick(1); check_issue("t2", 32'h1234, 32'd2, 6'h20);
    tick(4); check_done("t2", 6'h20);

    // Dispatch bypass: broadcast of the missing tag in the dispatch cycle.
    disp(32'hBEEF, 6'h09, 1'b0, 32'd4, 6'h00, 1'b1, 6'h21);
    cdb(1'b1, 6'h09, 32'hAA);
    tick(1); no_disp(); cdb(1'b0, '0, '0);
    check("t3_en_early", {31'd0, issuemult_enable}, 32'd0);
    tick(1); check_issue("t3", 32'hAA, 32'd4, 6'h21);
    tick(4); check_done("t3", 6'h21);

    // Fill all four slots waiting on tag 0x01; a fifth dispatch must be dropped.
    for (int k = 0; k < 4; k++) begin
      disp(32'hBAD, 6'h01, 1'b0, k, 6'h00, 1'b1, 6'h30 + 6'(k));
      tick(1);
      check($sformatf("t4_full_%0d", k), {31'd0, issueque_full}, (k == 3) ? 32'd1 : 32'd0);
    end
    disp(32'h5, 6'h00, 1'b1, 32'h6, 6'h00, 1'b1, 6'h3F);
    tick(1); no_disp(); cdb(1'b1, 6'h01, 32'h100);
    check("t4_drop_en", {31'd0, issuemult_enable}, 32'd0);
    check("t4_full_hold", {31'd0, issueque_full}, 32'd1);
    tick(1); cdb(1'b0, '0, '0);
    check("t4_wake_en", {31'd0, issuemult_enable}, 32'd0);
    check("t4_full_wake", {31'd0, issueque_full}, 32'd1);
    tick(1); check_issue("t4_0", 32'h100, 32'd0, 6'h30);
    check("t4_full_drop", {31'd0, issueque_full}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick(1); check_issue($sformatf("t4_%0d", k), 32'h100, k, 6'h30 + 6'(k));
    end
    tick(1); check("t4_no_fifth", {31'd0, issuemult_enable}, 32'd0);
    check_done("t4_0", 6'h30);
    tick(3); check_done("t4_3", 6'h33);
    tick(1); check("t4_done_end", {31'd0, issuemult_done}, 32'd0);

    // Two entries woken together, then dispatch in the same cycle as the first issue.
    disp(32'h0, 6'h02, 1'b0, 32'd7, 6'h00, 1'b1, 6'h40);
    tick(1); disp(32'h0, 6'h02, 1'b0, 32'd9, 6'h00, 1'b1, 6'h41);
    tick(1); no_disp(); cdb(1'b1, 6'h02, 32'h50);
    tick(1); cdb(1'b0, '0, '0);
    disp(32'h11, 6'h00, 1'b1, 32'h22, 6'h00, 1'b1, 6'h42);
    check("t5_en_wake", {31'd0, issuemult_enable}, 32'd0);
    tick(1); no_disp(); check_issue("t5_a", 32'h50, 32'd7, 6'h40);
    tick(1); check_issue("t5_b", 32'h50, 32'd9, 6'h41);
    tick(1); check_issue("t5_c", 32'h11, 32'h22, 6'h42);
    tick(1); check("t5_empty", {31'd0, issuemult_enable}, 32'd0);
    tick(1); check_done("t5_a", 6'h40);
    tick(1); check_done("t5_b", 6'h41);
    tick(1); check_done("t5_c", 6'h42);
    tick(1); check("t5_done_end", {31'd0, issuemult_done}, 32'd0);

    // Reset with two products in flight and one entry queued.
    disp(32'd2, 6'h00, 1'b1, 32'd3, 6'h00, 1'b1, 6'h50);
    tick(1); disp(32'd4, 6'h00, 1'b1, 32'd5, 6'h00, 1'b1, 6'h51);
    tick(1); disp(32'h0, 6'h03, 1'b0, 32'd6, 6'h00, 1'b1, 6'h52);
    tick(1); no_disp();
    check_issue("t6_y", 32'd4, 32'd5, 6'h51);
    reset = 1'b1;
    #1;
    check("t6_rst_en",   {31'd0, issuemult_enable}, 32'd0);
    check("t6_rst_done", {31'd0, issuemult_done}, 32'd0);
    check("t6_rst_full", {31'd0, issueque_full}, 32'd0);
    check("t6_rst_rs",   issuemult_rsdata, 32'd0);
    tick(2); reset = 1'b0;
    cdb(1'b1, 6'h03, 32'h77);
    tick(1); cdb(1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t6_post_en_%0d", k), {31'd0, issuemult_enable}, 32'd0);
      check($sformatf("t6_post_done_%0d", k), {31'd0, issuemult_done}, 32'd0);
      check($sformatf("t6_post_full_%0d", k), {31'd0, issueque_full}, 32'd0);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
